// File: rtl/dcache_arbiter_pkg.sv
// Shared types and constants for the data-cache front-end arbiter and its fill buffer.
package dcache_arbiter_pkg;

  localparam int DC_ADDR_W      = 32;
  localparam int BLOCK_W        = 1024;
  localparam int MEM_BEAT_W     = 128;
  localparam int DC_BLOCK_BYTES = BLOCK_W / 8;
  localparam int DC_OFFSET_W    = $clog2(DC_BLOCK_BYTES);

  typedef enum logic [2:0] {
    DC_IDLE     = 3'd0,
    DC_MEM_REQ  = 3'd1,
    DC_MEM_FILL = 3'd2,
    DC_INSTALL  = 3'd3,
    DC_RESOLVE  = 3'd4,
    DC_REPLAY   = 3'd5
  } dc_arb_state_e;

  // Clears the byte-offset bits so the address points at the start of its block.
  function automatic logic [DC_ADDR_W-1:0] block_offset_mask(input logic [DC_ADDR_W-1:0] addr);
    logic [DC_ADDR_W-1:0] keep;
    keep = '1;
    keep[DC_OFFSET_W-1:0] = '0;
    return addr & keep;
  endfunction

endpackage

// File: rtl/dcache_fill_buffer.sv
// Assembles a cache block from sequential memory beats; beat 0 lands in the lowest bits.
module dcache_fill_buffer
  import dcache_arbiter_pkg::*;
#(
  parameter int BLOCK_W    = dcache_arbiter_pkg::BLOCK_W,
  parameter int MEM_BEAT_W = dcache_arbiter_pkg::MEM_BEAT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  beat_valid,
  input  logic [MEM_BEAT_W-1:0] beat_data,
  output logic [BLOCK_W-1:0]    block,
  output logic                  done
);

  localparam int BEATS = BLOCK_W / MEM_BEAT_W;
  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0] beat_cnt_q;
  logic             beat_take;
  logic             beat_last;

  assign beat_take = en & beat_valid;
  assign beat_last = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign done      = beat_take & beat_last;

  // Beats are only accepted while enabled; reset discards any partial block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q <= '0;
      block      <= '0;
    end else if (beat_take) begin
      block[beat_cnt_q*MEM_BEAT_W +: MEM_BEAT_W] <= beat_data;
      beat_cnt_q <= beat_last ? '0 : beat_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_arbiter.sv
// Shares the dCacheController request port between load and store units and services read-miss repairs.
module dcache_arbiter
  import dcache_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DC_ADDR_W,
  parameter int BLOCK_W    = dcache_arbiter_pkg::BLOCK_W,
  parameter int MEM_BEAT_W = dcache_arbiter_pkg::MEM_BEAT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_req,
  input  logic [ADDR_W-1:0]      ld_addr,
  output logic                   ld_gnt,
  input  logic                   st_req,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [BLOCK_W-1:0]     st_data,
  input  logic [BLOCK_W/8-1:0]   st_mask,
  output logic                   st_gnt,
  output logic                   c_raddr_valid,
  output logic [ADDR_W-1:0]      c_raddr,
  output logic                   c_waddr_valid,
  output logic [ADDR_W-1:0]      c_waddr,
  output logic [BLOCK_W-1:0]     c_wdata,
  output logic [BLOCK_W/8-1:0]   c_wmask,
  input  logic                   c_read_repair_request,
  input  logic [ADDR_W-1:0]      c_missed_addr,
  output logic                   c_repair_resolved,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [MEM_BEAT_W-1:0]  mem_rdata
);

  dc_arb_state_e        state_q, state_d;
  logic                 ptr_q, ptr_d;       // 0: load has priority, 1: store has priority
  logic                 latch_miss;
  logic [ADDR_W-1:0]    missed_addr_q;
  logic [BLOCK_W-1:0]   fill_block;
  logic                 fill_done;
  logic                 rd_vld_p1, wr_vld_p1;
  logic [ADDR_W-1:0]    rd_addr_p1, wr_addr_p1;
  logic [BLOCK_W-1:0]   wr_data_p1;
  logic [BLOCK_W/8-1:0] wr_mask_p1;
  logic                 in_install, in_replay;

  dcache_fill_buffer #(
    .BLOCK_W    (BLOCK_W),
    .MEM_BEAT_W (MEM_BEAT_W)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q == DC_MEM_FILL),
    .beat_valid (mem_rvalid),
    .beat_data  (mem_rdata),
    .block      (fill_block),
    .done       (fill_done)
  );

  // Next-state, grant and round-robin pointer logic; grants only exist in IDLE.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ld_gnt     = 1'b0;
    st_gnt     = 1'b0;
    latch_miss = 1'b0;
    case (state_q)
      DC_IDLE: begin
        if (c_read_repair_request) begin
          latch_miss = 1'b1;
          state_d    = DC_MEM_REQ;
        end else if (ld_req && st_req) begin
          ld_gnt = ~ptr_q;
          st_gnt = ptr_q;
          ptr_d  = ~ptr_q;
        end else begin
          ld_gnt = ld_req;
          st_gnt = st_req;
        end
      end
      DC_MEM_REQ:  if (mem_gnt)   state_d = DC_MEM_FILL;
      DC_MEM_FILL: if (fill_done) state_d = DC_INSTALL;
      DC_INSTALL:  state_d = DC_RESOLVE;
      DC_RESOLVE:  state_d = DC_REPLAY;
      DC_REPLAY:   state_d = DC_IDLE;
      default:     state_d = DC_IDLE;
    endcase
  end

  // State, priority pointer and the address of the miss being repaired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= DC_IDLE;
      ptr_q         <= 1'b0;
      missed_addr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (latch_miss) missed_addr_q <= c_missed_addr;
    end
  end

  // ---- stage p1: granted request registered onto the controller port ----
  // Address and data are zeroed when no grant was issued so idle outputs read 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_p1  <= 1'b0;
      rd_addr_p1 <= '0;
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      wr_mask_p1 <= '0;
    end else begin
      rd_vld_p1  <= ld_gnt;
      rd_addr_p1 <= ld_gnt ? ld_addr : '0;
      wr_vld_p1  <= st_gnt;
      wr_addr_p1 <= st_gnt ? st_addr : '0;
      wr_data_p1 <= st_gnt ? st_data : '0;
      wr_mask_p1 <= st_gnt ? st_mask : '0;
    end
  end

  // A registered grant pulse is only ever live in IDLE, so it never overlaps INSTALL or REPLAY.
  assign in_install        = (state_q == DC_INSTALL);
  assign in_replay         = (state_q == DC_REPLAY);
  assign c_raddr_valid     = rd_vld_p1 | in_replay;
  assign c_raddr           = in_replay ? missed_addr_q : rd_addr_p1;
  assign c_waddr_valid     = wr_vld_p1 | in_install;
  assign c_waddr           = in_install ? missed_addr_q : wr_addr_p1;
  assign c_wdata           = in_install ? fill_block : wr_data_p1;
  assign c_wmask           = in_install ? '1 : wr_mask_p1;
  assign c_repair_resolved = (state_q == DC_RESOLVE);
  assign mem_req           = (state_q == DC_MEM_REQ);
  assign mem_addr          = mem_req ? block_offset_mask(missed_addr_q) : '0;

endmodule
